// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer.
// Optional build macro: FFT_SEQ_HALF_EN drains only bins 0..4 (real-input half spectrum).
package fft_seq_pkg;

    localparam int unsigned FFT_N     = 8;
    localparam int unsigned FFT_IDX_W = 3;

`ifdef FFT_SEQ_HALF_EN
    // Real input gives a conjugate-symmetric spectrum; bins 5..7 carry no new information.
    localparam int unsigned FFT_LAST = 4;
`else
    localparam int unsigned FFT_LAST = 7;
`endif

    typedef logic [FFT_IDX_W-1:0] bin_idx_t;

    typedef enum logic [1:0] {
        StFill,
        StWait,
        StDrain
    } seq_state_e;

endpackage

// File: rtl/fft_frame_sequencer.sv
// Gathers 8 samples into a frame for the external FFT core, waits out the core latency,
// captures the bins and drains them one per handshake.
// Optional build macro: FFT_SEQ_HALF_EN (drain and store bins 0..4 only).
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned N       = 8,
    parameter int unsigned FFT_LAT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_sample,
    output logic [N*DATA_W-1:0] frame_o,
    input  logic [N*DATA_W-1:0] fft_re_i,
    input  logic [N*DATA_W-1:0] fft_im_i,
    output logic                bin_valid,
    input  logic                bin_ready,
    output logic [DATA_W-1:0]   bin_re,
    output logic [DATA_W-1:0]   bin_im,
    output logic [2:0]          bin_idx,
    output logic                bin_last,
    output logic                busy
);

    localparam int unsigned NumBins  = FFT_LAST + 1;
    localparam bin_idx_t    LastIdx  = bin_idx_t'(FFT_LAST);
    localparam bin_idx_t    FrameEnd = bin_idx_t'(FFT_N - 1);
    localparam logic [3:0]  LatInit  = 4'(FFT_LAT);

    seq_state_e state_q, state_d;
    bin_idx_t   wr_idx_q, wr_idx_d;
    bin_idx_t   rd_idx_q, rd_idx_d;
    logic [3:0] lat_cnt_q, lat_cnt_d;

    logic [N*DATA_W-1:0] frame_q;
    logic [DATA_W-1:0]   res_re_q [NumBins];
    logic [DATA_W-1:0]   res_im_q [NumBins];

    logic in_hs;
    logic bin_hs;
    logic capture;

`ifdef FFT_SEQ_HALF_EN
    // Bins 5..7 of the core are intentionally not stored.
    logic unused_bins;
    assign unused_bins = ^{fft_re_i, fft_im_i};
`endif

    // Handshake flags are decoded from registered state only.
    assign in_ready  = (state_q == StFill);
    assign busy      = (state_q != StFill);
    assign bin_valid = (state_q == StDrain);
    assign bin_last  = bin_valid && (rd_idx_q == LastIdx);
    assign bin_idx   = rd_idx_q;
    assign bin_re    = bin_valid ? res_re_q[rd_idx_q] : '0;
    assign bin_im    = bin_valid ? res_im_q[rd_idx_q] : '0;
    assign frame_o   = frame_q;

    assign in_hs   = in_valid && in_ready;
    assign bin_hs  = bin_valid && bin_ready;
    assign capture = (state_q == StWait) && (lat_cnt_q == '0);

    // Next-state logic for the FSM and its index/latency counters.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        lat_cnt_d = lat_cnt_q;
        unique case (state_q)
            StFill: begin
                if (in_hs) begin
                    if (wr_idx_q == FrameEnd) begin
                        wr_idx_d  = '0;
                        lat_cnt_d = LatInit;
                        state_d   = StWait;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            StWait: begin
                if (lat_cnt_q == '0) begin
                    rd_idx_d = '0;
                    state_d  = StDrain;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            StDrain: begin
                if (bin_hs) begin
                    if (rd_idx_q == LastIdx) begin
                        rd_idx_d = '0;
                        state_d  = StFill;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFill;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Frame buffer writes and result capture; both cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            for (int k = 0; k < NumBins; k++) begin
                res_re_q[k] <= '0;
                res_im_q[k] <= '0;
            end
        end else begin
            if (in_hs) begin
                frame_q[wr_idx_q*DATA_W +: DATA_W] <= in_sample;
            end
            if (capture) begin
                for (int k = 0; k < NumBins; k++) begin
                    res_re_q[k] <= fft_re_i[k*DATA_W +: DATA_W];
                    res_im_q[k] <= fft_im_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer with a pipelined stub FFT core.
module tb_fft_frame_sequencer;

    localparam int W       = 12;
    localparam int N       = 8;
    localparam int FFT_LAT = 3;
`ifdef FFT_SEQ_HALF_EN
    localparam int LAST = 4;
`else
    localparam int LAST = 7;
`endif
    localparam int PERIOD = N + FFT_LAT + 1 + LAST + 1;
    localparam int PIDX   = (FFT_LAT == 0) ? 0 : FFT_LAT - 1;
    localparam logic [126:0] RST_EXP = {1'b1, 126'd0};

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [2:0]   idx;
        logic         last;
    } bin_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_sample;
    logic [N*W-1:0] frame_o;
    logic [N*W-1:0] fft_re;
    logic [N*W-1:0] fft_im;
    logic           bin_valid;
    logic           bin_ready;
    logic [W-1:0]   bin_re;
    logic [W-1:0]   bin_im;
    logic [2:0]     bin_idx;
    logic           bin_last;
    logic           busy;
    logic [126:0]   outs;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   in_cnt   = 0;
    bin_t exp_q[$];
    int   done_q[$];
    int   frame_start[$];

    fft_frame_sequencer #(.DATA_W(W), .N(N), .FFT_LAT(FFT_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .frame_o   (frame_o),
        .fft_re_i  (fft_re),
        .fft_im_i  (fft_im),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .bin_re    (bin_re),
        .bin_im    (bin_im),
        .bin_idx   (bin_idx),
        .bin_last  (bin_last),
        .busy      (busy)
    );

    assign outs = {in_ready, bin_valid, bin_last, busy, bin_idx, bin_re, bin_im, frame_o};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub core transfer function, also used by the reference model.
    function automatic logic [W-1:0] stub_re(input logic [W-1:0] s, input int k);
        return s + W'(100 + k);
    endfunction
    function automatic logic [W-1:0] stub_im(input logic [W-1:0] s);
        return W'(0) - s;
    endfunction

    // Stub core: combinational function followed by FFT_LAT pipeline registers.
    logic [2*N*W-1:0] pre;
    logic [2*N*W-1:0] pipe [FFT_LAT+1];
    always_comb begin
        pre = '0;
        for (int k = 0; k < N; k++) begin
            pre[N*W + k*W +: W] = stub_re(frame_o[k*W +: W], k);
            pre[k*W +: W]       = stub_im(frame_o[k*W +: W]);
        end
    end
    always @(posedge clk) begin
        pipe[0] <= pre;
        for (int i = 1; i <= FFT_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {fft_re, fft_im} = (FFT_LAT == 0) ? pre : pipe[PIDX];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Input monitor / reference model: builds expected bins from accepted samples.
    initial begin
        logic [W-1:0] cur[$];
        bin_t b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur.delete();
            end else if (in_valid && in_ready) begin
                if (cur.size() == 0) frame_start.push_back(cyc);
                cur.push_back(in_sample);
                if (cur.size() == N) begin
                    for (int k = 0; k <= LAST; k++) begin
                        b.re   = stub_re(cur[k], k);
                        b.im   = stub_im(cur[k]);
                        b.idx  = 3'(k);
                        b.last = (k == LAST);
                        exp_q.push_back(b);
                    end
                    done_q.push_back(cyc);
                    cur.delete();
                end
            end
            in_cnt = cur.size();
        end
    end

    // Output monitor: checks flags against frame timing and pops bins on handshake.
    initial begin
        bit   draining = 0;
        bit   pend;
        bin_t b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                done_q.delete();
                draining = 0;
            end else begin
                if (!draining && done_q.size() > 0 && cyc >= done_q[0] + FFT_LAT + 2) begin
                    draining = 1;
                    void'(done_q.pop_front());
                end
                pend = draining || (done_q.size() > 0 && cyc > done_q[0]);
                if (draining) begin
                    chk("status", 128'({in_ready, busy, bin_valid}), 128'({1'b0, 1'b1, 1'b1}));
                    if (exp_q.size() == 0) begin
                        chk("bin_unexpected", 128'(bin_valid), 128'(0));
                    end else begin
                        chk("bin", 128'({bin_re, bin_im, bin_idx, bin_last}), 128'(exp_q[0]));
                        if (bin_ready) begin
                            b = exp_q.pop_front();
                            if (b.last) draining = 0;
                        end
                    end
                end else begin
                    chk("status", 128'({in_ready, busy, bin_valid, bin_last}),
                        128'({!pend, pend, 1'b0, 1'b0}));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] held;
        rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; bin_ready = 1'b1;
        #2;
        chk("reset_outputs", 128'(outs), 128'(RST_EXP));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_state", 128'(outs), 128'(RST_EXP));

        // Samples 1..8 back-to-back, in_valid kept high through WAIT/DRAIN.
        in_valid = 1'b1; in_sample = 12'd1;
        for (int k = 2; k <= N; k++) begin
            step();
            in_sample = W'(k);
        end
        step();
        chk("in_ready_drop", 128'(in_ready), 128'(0));
        for (int k = 0; k < N; k++) chk("frame_slot", 128'(frame_o[k*W +: W]), 128'(k + 1));
        for (int i = 0; i < 2 * PERIOD + 4; i++) begin
            in_sample = W'($urandom);
            step();
        end
        chk("frame_period", 128'(frame_start.size() >= 2 ? frame_start[1] - frame_start[0] : -1),
            128'(PERIOD));

        // Backpressure at idx 2 for 5 cycles.
        bin_ready = 1'b0;
        for (int i = 0; i < 100 && !bin_valid; i++) step();
        for (int i = 0; i < 20 && bin_idx != 3'd2; i++) begin
            bin_ready = 1'b1;
            step();
            bin_ready = 1'b0;
        end
        chk("bp_reach_idx2", 128'({bin_valid, bin_idx}), 128'({1'b1, 3'd2}));
        held = {bin_re, bin_im, bin_idx, bin_last};
        repeat (5) begin
            step();
            chk("bp_hold", 128'({bin_valid, bin_re, bin_im, bin_idx, bin_last}),
                128'({1'b1, held}));
        end
        bin_ready = 1'b1;

        // Random traffic on both sides.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sample = W'($urandom);
            bin_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset while the 5th sample is presented.
        bin_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 100 && !(in_ready && in_cnt == 4); i++) begin
            in_sample = W'($urandom);
            step();
        end
        chk("reach_5th_sample", 128'(in_cnt), 128'(4));
        #1 rst_n = 1'b0;
        #1 chk("reset_mid_fill", 128'(outs), 128'(RST_EXP));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_sample = W'(200 + k);
            step();
        end
        for (int k = 0; k < N; k++) chk("restart_slot", 128'(frame_o[k*W +: W]), 128'(200 + k));

        // Reset while bin 3 is on the output.
        for (int i = 0; i < 100 && !(bin_valid && bin_idx == 3'd3); i++) begin
            in_sample = W'($urandom);
            step();
        end
        chk("reach_idx3", 128'({bin_valid, bin_idx}), 128'({1'b1, 3'd3}));
        #1 rst_n = 1'b0;
        #1 chk("reset_mid_drain", 128'(outs), 128'(RST_EXP));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sample = W'($urandom);
            bin_ready = ($urandom_range(0, 1) != 0);
            step();
        end

        // Flush: no bins may be left behind.
        in_valid = 1'b0; bin_ready = 1'b1;
        repeat (3 * PERIOD) step();
        chk("scoreboard_empty", 128'(exp_q.size() + done_q.size()), 128'(0));
        chk("idle_after_flush", 128'({in_ready, busy, bin_valid}), 128'({1'b1, 1'b0, 1'b0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
